mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter sharing the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multicycle NPC core. It accepts one request at a time over valid/ready handshakes, drives the memory unit's access/read/write strobes for exactly one cycle, waits the fixed memory latency and returns the result as a one-cycle response pulse to the winning requester. It sits between IFU/LSU and the memory unit.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LAT, 1, cycles from the memory-issue edge to valid mem_rdata; legal 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address (word read).
- ifu_resp_valid  out  1  one-cycle fetch response pulse.
- ifu_rdata  out  DATA_W  fetched word; valid with ifu_resp_valid.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  load/store request accepted this cycle.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  8  store byte mask.
- lsu_readop  in  3  load size/sign code, forwarded to memory.
- lsu_resp_valid  out  1  one-cycle load data / store ack pulse.
- lsu_rdata  out  DATA_W  load data; 0 for stores.
- mem_access  out  1  memory strobe, high one cycle per transaction.
- mem_read  out  1  read request.
- mem_wen  out  1  write request.
- mem_readop  out  3  read size code (3'h2 for fetches).
- mem_wmask  out  8  write mask.
- mem_raddr, mem_waddr  out  ADDR_W  read / write address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: ready asserted combinationally to at most one requester (the arbitration winner among those with valid high); no ready when no valid. On handshake (valid & ready) latch address, wen, wdata, wmask, readop and owner; go ISSUE.
- Arbitration on simultaneous valid: see Configuration. Lone requester always wins.
- ISSUE: mem_access=1; load/fetch → mem_read=1, mem_wen=0, mem_raddr=latched addr; store → mem_wen=1, mem_read=0, mem_waddr=latched addr, mem_wdata, mem_wmask driven. Fetch drives mem_readop=3'h2. Load cycle counter with LAT; go WAIT.
- WAIT: counter decrements each cycle; when it reaches 1, capture mem_rdata (reads) or 0 (stores) into response register; go RESP.
- RESP: owner's resp_valid=1 for exactly one cycle with registered rdata; go IDLE.
- All mem_* outputs are 0 outside ISSUE. rdata outputs hold last value between pulses.
- No request queueing; requesters hold valid (and payload) until ready.

## Timing
- Reset values: all ready, resp_valid, mem_* and rdata outputs 0; state IDLE; counter 0; last-grant = LSU.
- Handshake in cycle 0 → ISSUE in cycle 1 → WAIT cycles 2..1+LAT (mem_rdata sampled at end of cycle 1+LAT) → RESP in cycle 2+LAT → IDLE (ready possible) in cycle 3+LAT.
- Throughput: one transaction per LAT+3 cycles.
- Valid dropped before handshake: no effect. Valid changed during ISSUE/WAIT/RESP: ignored.
- rst_n low at any point: immediate return to reset values, in-flight transaction dropped, no response pulse.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous valid, grant the requester not granted last; last-grant register updates on every handshake.
- Undefined: fixed priority, LSU always wins on conflict; last-grant register not implemented.

## Test plan
- LAT=1, IFU only, addr 0x80000000, memory returns 0x00000413 → ifu_req_ready cycle 0, mem_access/mem_read cycle 1 with mem_raddr=0x80000000, ifu_resp_valid cycle 3 with ifu_rdata=0x00000413.
- LSU store addr 0x80001004, wdata 0xDEADBEEF, wmask 0x0F → mem_wen=1 one cycle with those values, mem_read=0, lsu_resp_valid pulse with lsu_rdata=0.
- Both valid from cycle 0, held: fixed priority → LSU granted, IFU granted at cycle 4 (LAT=1); round-robin after reset → IFU first, LSU second, alternating thereafter.
- LAT=4, load readop 3'h0 → mem_readop=3'h0, rdata sampled cycle 5, lsu_resp_valid cycle 6, no ready asserted cycles 1–6.
- rst_n low during WAIT → mem_* and resp_valid 0 immediately, state IDLE; no response after release; next request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: one transaction at a time, fixed latency LAT.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin on conflict (default: LSU has fixed priority).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  input  logic [2:0]        lsu_readop,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_access,
  output logic              mem_read,
  output logic              mem_wen,
  output logic [2:0]        mem_readop,
  output logic [7:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wmask;
  logic [2:0]        r_readop;
  logic              r_owner_lsu;
  logic [DATA_W-1:0] r_ifu_rdata, r_lsu_rdata;
  logic              w_prio_lsu, w_grant_lsu, w_grant_ifu, w_hs;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_lsu;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_last_lsu <= 1'b1;
    else if (w_hs) r_last_lsu <= w_grant_lsu;
  end
  assign w_prio_lsu = ~r_last_lsu;
`else
  assign w_prio_lsu = 1'b1;
`endif

  // Handshake: a transfer happens in a cycle where valid & ready are both high.
  // Ready is only offered in IDLE, to at most one requester, and never without valid;
  // requesters hold valid and payload stable until they see ready.
  always_comb begin
    w_grant_lsu = 1'b0;
    w_grant_ifu = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant_lsu = lsu_req_valid & (~ifu_req_valid | w_prio_lsu);
      w_grant_ifu = ifu_req_valid & ~w_grant_lsu;
    end
  end

  assign w_hs          = w_grant_lsu | w_grant_ifu;
  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_readop    <= '0;
      r_owner_lsu <= 1'b0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_hs) begin
          // Fetches are always word reads, so their size code is fixed here.
          r_addr      <= w_grant_lsu ? lsu_addr : ifu_addr;
          r_wen       <= w_grant_lsu & lsu_wen;
          r_wdata     <= w_grant_lsu ? lsu_wdata : '0;
          r_wmask     <= w_grant_lsu ? lsu_wmask : '0;
          r_readop    <= w_grant_lsu ? lsu_readop : 3'h2;
          r_owner_lsu <= w_grant_lsu;
        end
        S_ISSUE: r_cnt <= 3'(LAT);
        S_WAIT: begin
          if (r_cnt == 3'd1) begin
            r_cnt <= '0;
            if (r_owner_lsu) r_lsu_rdata <= r_wen ? '0 : mem_rdata;
            else             r_ifu_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_access     = 1'b0;
    mem_read       = 1'b0;
    mem_wen        = 1'b0;
    mem_readop     = '0;
    mem_wmask      = '0;
    mem_raddr      = '0;
    mem_waddr      = '0;
    mem_wdata      = '0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    if (r_state == S_ISSUE) begin
      mem_access = 1'b1;
      if (r_wen) begin
        mem_wen   = 1'b1;
        mem_waddr = r_addr;
        mem_wdata = r_wdata;
        mem_wmask = r_wmask;
      end else begin
        mem_read   = 1'b1;
        mem_raddr  = r_addr;
        mem_readop = r_readop;
      end
    end
    if (r_state == S_RESP) begin
      ifu_resp_valid = ~r_owner_lsu;
      lsu_resp_valid = r_owner_lsu;
    end
  end

  assign ifu_rdata = r_ifu_rdata;
  assign lsu_rdata = r_lsu_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a_ uses LAT=1, instance b_ uses LAT=4; both share inputs.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ifu_req_valid, lsu_req_valid, lsu_wen;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [7:0]  lsu_wmask;
  logic [2:0]  lsu_readop;

  logic        a_ifu_req_ready, a_ifu_resp_valid, a_lsu_req_ready, a_lsu_resp_valid;
  logic        a_mem_access, a_mem_read, a_mem_wen;
  logic [2:0]  a_mem_readop;
  logic [7:0]  a_mem_wmask;
  logic [31:0] a_ifu_rdata, a_lsu_rdata, a_mem_raddr, a_mem_waddr, a_mem_wdata;
  logic [1:0]  a_dbg_state;
  logic        b_ifu_req_ready, b_ifu_resp_valid, b_lsu_req_ready, b_lsu_resp_valid;
  logic        b_mem_access, b_mem_read, b_mem_wen;
  logic [2:0]  b_mem_readop;
  logic [7:0]  b_mem_wmask;
  logic [31:0] b_ifu_rdata, b_lsu_rdata, b_mem_raddr, b_mem_waddr, b_mem_wdata;
  logic [1:0]  b_dbg_state;

  int cmp_cnt = 0;
  int err_cnt = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(a_ifu_resp_valid), .ifu_rdata(a_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_readop(lsu_readop),
    .lsu_resp_valid(a_lsu_resp_valid), .lsu_rdata(a_lsu_rdata),
    .mem_access(a_mem_access), .mem_read(a_mem_read), .mem_wen(a_mem_wen),
    .mem_readop(a_mem_readop), .mem_wmask(a_mem_wmask), .mem_raddr(a_mem_raddr),
    .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(a_dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(b_ifu_resp_valid), .ifu_rdata(b_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_readop(lsu_readop),
    .lsu_resp_valid(b_lsu_resp_valid), .lsu_rdata(b_lsu_rdata),
    .mem_access(b_mem_access), .mem_read(b_mem_read), .mem_wen(b_mem_wen),
    .mem_readop(b_mem_readop), .mem_wmask(b_mem_wmask), .mem_raddr(b_mem_raddr),
    .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(b_dbg_state)
  );

  // Advance to just after the next rising edge; cycle boundaries are counted from here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;
    ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; lsu_readop = '0; mem_rdata = '0;
    #12;
    cmp_cnt++; if (a_dbg_state !== 2'd0) begin err_cnt++; $display("FAIL reset_state got %0d exp 0", a_dbg_state); end
    cmp_cnt++;
    if ({a_ifu_req_ready, a_lsu_req_ready, a_ifu_resp_valid, a_lsu_resp_valid, a_mem_access, a_mem_read, a_mem_wen} !== 7'd0 ||
        {a_mem_readop, a_mem_wmask, a_mem_raddr, a_mem_waddr, a_mem_wdata, a_ifu_rdata, a_lsu_rdata} !== '0) begin
      err_cnt++; $display("FAIL reset_outputs got nonzero output, exp all 0");
    end
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    cmp_cnt++; if ({a_ifu_req_ready, a_lsu_req_ready, a_mem_access} !== 3'd0) begin err_cnt++; $display("FAIL reset_release_noready got %b exp 000", {a_ifu_req_ready, a_lsu_req_ready, a_mem_access}); end
  endtask

  task automatic test_ifu_fetch();
    cyc(); ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    @(negedge clk);
    cmp_cnt++; if (a_ifu_req_ready !== 1'b1 || a_lsu_req_ready !== 1'b0) begin err_cnt++; $display("FAIL fetch_ready_c0 got ifu=%b lsu=%b exp 1 0", a_ifu_req_ready, a_lsu_req_ready); end
    cyc(); ifu_req_valid = 1'b0; mem_rdata = 32'h0000_0413;
    @(negedge clk);
    cmp_cnt++; if ({a_mem_access, a_mem_read, a_mem_wen} !== 3'b110) begin err_cnt++; $display("FAIL fetch_strobes_c1 got %b exp 110", {a_mem_access, a_mem_read, a_mem_wen}); end
    cmp_cnt++; if (a_mem_raddr !== 32'h8000_0000 || a_mem_readop !== 3'h2) begin err_cnt++; $display("FAIL fetch_addr_c1 got %h/%h exp 80000000/2", a_mem_raddr, a_mem_readop); end
    cyc();
    @(negedge clk);
    cmp_cnt++; if ({a_mem_access, a_ifu_resp_valid} !== 2'b00) begin err_cnt++; $display("FAIL fetch_wait_c2 got %b exp 00", {a_mem_access, a_ifu_resp_valid}); end
    cyc(); mem_rdata = 32'h1234_5678;
    @(negedge clk);
    cmp_cnt++; if (a_ifu_resp_valid !== 1'b1 || a_ifu_rdata !== 32'h0000_0413 || a_lsu_resp_valid !== 1'b0) begin err_cnt++; $display("FAIL fetch_resp_c3 got v=%b d=%h exp 1 00000413", a_ifu_resp_valid, a_ifu_rdata); end
    cyc();
    @(negedge clk);
    cmp_cnt++; if (a_ifu_resp_valid !== 1'b0 || a_ifu_rdata !== 32'h0000_0413 || a_dbg_state !== 2'd0) begin err_cnt++; $display("FAIL fetch_hold_c4 got v=%b d=%h st=%0d exp 0 00000413 0", a_ifu_resp_valid, a_ifu_rdata, a_dbg_state); end
    idle(8);
  endtask

  task automatic test_store();
    cyc(); lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1004; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    cmp_cnt++; if (a_lsu_req_ready !== 1'b1) begin err_cnt++; $display("FAIL store_ready_c0 got %b exp 1", a_lsu_req_ready); end
    cyc(); lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    @(negedge clk);
    cmp_cnt++; if ({a_mem_access, a_mem_read, a_mem_wen} !== 3'b101) begin err_cnt++; $display("FAIL store_strobes_c1 got %b exp 101", {a_mem_access, a_mem_read, a_mem_wen}); end
    cmp_cnt++; if (a_mem_waddr !== 32'h8000_1004 || a_mem_wdata !== 32'hDEAD_BEEF || a_mem_wmask !== 8'h0F || a_mem_raddr !== 32'h0) begin
      err_cnt++; $display("FAIL store_payload_c1 got a=%h d=%h m=%h ra=%h exp 80001004 deadbeef 0f 0", a_mem_waddr, a_mem_wdata, a_mem_wmask, a_mem_raddr);
    end
    cyc();
    @(negedge clk);
    cmp_cnt++; if (a_mem_wen !== 1'b0) begin err_cnt++; $display("FAIL store_wen_one_cycle got %b exp 0", a_mem_wen); end
    cyc();
    @(negedge clk);
    cmp_cnt++; if (a_lsu_resp_valid !== 1'b1 || a_lsu_rdata !== 32'h0 || a_ifu_resp_valid !== 1'b0) begin err_cnt++; $display("FAIL store_ack_c3 got v=%b d=%h exp 1 0", a_lsu_resp_valid, a_lsu_rdata); end
    idle(8);
  endtask

  task automatic test_conflict();
    logic w0_lsu;
    w0_lsu = ~RR;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cyc(); ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100; lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0200; lsu_readop = 3'h4;
    mem_rdata = 32'hABCD_0001;
    @(negedge clk);
    cmp_cnt++; if (a_lsu_req_ready !== w0_lsu || a_ifu_req_ready !== ~w0_lsu) begin err_cnt++; $display("FAIL conflict_first_grant got lsu=%b ifu=%b exp lsu=%b", a_lsu_req_ready, a_ifu_req_ready, w0_lsu); end
    cyc(); if (w0_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    @(negedge clk);
    cmp_cnt++; if (a_mem_raddr !== (w0_lsu ? 32'h8000_0200 : 32'h8000_0100) || {a_ifu_req_ready, a_lsu_req_ready} !== 2'b00) begin
      err_cnt++; $display("FAIL conflict_issue_c1 got ra=%h rdy=%b", a_mem_raddr, {a_ifu_req_ready, a_lsu_req_ready});
    end
    cyc(); cyc();
    @(negedge clk);
    cmp_cnt++; if (a_lsu_resp_valid !== w0_lsu || a_ifu_resp_valid !== ~w0_lsu || {a_ifu_req_ready, a_lsu_req_ready} !== 2'b00) begin
      err_cnt++; $display("FAIL conflict_resp_c3 got lsu_v=%b ifu_v=%b exp lsu_v=%b", a_lsu_resp_valid, a_ifu_resp_valid, w0_lsu);
    end
    cyc();
    @(negedge clk);
    cmp_cnt++; if (a_lsu_req_ready !== ~w0_lsu || a_ifu_req_ready !== w0_lsu) begin err_cnt++; $display("FAIL conflict_second_grant_c4 got lsu=%b ifu=%b exp lsu=%b", a_lsu_req_ready, a_ifu_req_ready, ~w0_lsu); end
    cyc(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    cyc(); cyc();
    cyc(); ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    @(negedge clk);
    cmp_cnt++; if (a_lsu_req_ready !== w0_lsu || a_ifu_req_ready !== ~w0_lsu) begin err_cnt++; $display("FAIL conflict_third_grant_c8 got lsu=%b ifu=%b exp lsu=%b", a_lsu_req_ready, a_ifu_req_ready, w0_lsu); end
    cyc(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    idle(10);
  endtask

  task automatic test_lat4_load();
    cyc(); lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2008; lsu_readop = 3'h0; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    cmp_cnt++; if (b_lsu_req_ready !== 1'b1) begin err_cnt++; $display("FAIL lat4_ready_c0 got %b exp 1", b_lsu_req_ready); end
    cyc(); lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
    @(negedge clk);
    cmp_cnt++; if ({b_mem_access, b_mem_read} !== 2'b11 || b_mem_readop !== 3'h0 || b_mem_raddr !== 32'h8000_2008 || b_ifu_req_ready !== 1'b0) begin
      err_cnt++; $display("FAIL lat4_issue_c1 got acc/rd=%b op=%h ra=%h rdy=%b", {b_mem_access, b_mem_read}, b_mem_readop, b_mem_raddr, b_ifu_req_ready);
    end
    for (int c = 2; c <= 6; c++) begin
      cyc();
      if (c == 5) mem_rdata = 32'hCAFE_F00D;
      else if (c == 6) mem_rdata = 32'h2222_2222;
      @(negedge clk);
      cmp_cnt++; if ({b_ifu_req_ready, b_lsu_req_ready} !== 2'b00) begin err_cnt++; $display("FAIL lat4_noready_c%0d got %b exp 00", c, {b_ifu_req_ready, b_lsu_req_ready}); end
      cmp_cnt++; if (b_lsu_resp_valid !== (c == 6)) begin err_cnt++; $display("FAIL lat4_resp_valid_c%0d got %b exp %b", c, b_lsu_resp_valid, (c == 6)); end
      if (c == 6) begin
        cmp_cnt++; if (b_lsu_rdata !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL lat4_rdata_c6 got %h exp cafef00d", b_lsu_rdata); end
      end
    end
    cyc();
    @(negedge clk);
    cmp_cnt++; if (b_ifu_req_ready !== 1'b1) begin err_cnt++; $display("FAIL lat4_next_ready_c7 got %b exp 1", b_ifu_req_ready); end
    cyc(); ifu_req_valid = 1'b0;
    idle(10);
  endtask

  task automatic test_reset_in_wait();
    cyc(); ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010; mem_rdata = 32'h0000_0055;
    @(negedge clk);
    cmp_cnt++; if (b_ifu_req_ready !== 1'b1) begin err_cnt++; $display("FAIL rstw_ready_c0 got %b exp 1", b_ifu_req_ready); end
    cyc(); ifu_req_valid = 1'b0;
    cyc();
    @(negedge clk);
    cmp_cnt++; if (b_dbg_state !== 2'd2) begin err_cnt++; $display("FAIL rstw_in_wait_c2 got %0d exp 2", b_dbg_state); end
    cyc();
    cmp_cnt++; if (a_ifu_resp_valid !== 1'b1) begin err_cnt++; $display("FAIL rstw_a_resp_c3 got %b exp 1", a_ifu_resp_valid); end
    rst_n = 1'b0; #1;
    cmp_cnt++; if (b_dbg_state !== 2'd0 || a_ifu_resp_valid !== 1'b0 || a_ifu_rdata !== 32'h0 || {b_mem_access, b_mem_read, b_ifu_resp_valid} !== 3'b000) begin
      err_cnt++; $display("FAIL rstw_immediate got st=%0d a_v=%b a_d=%h exp 0 0 0", b_dbg_state, a_ifu_resp_valid, a_ifu_rdata);
    end
    cyc(); cyc(); rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cmp_cnt++; if (b_ifu_resp_valid !== 1'b0 || b_ifu_rdata !== 32'h0) begin err_cnt++; $display("FAIL rstw_no_resp_%0d got v=%b d=%h exp 0 0", c, b_ifu_resp_valid, b_ifu_rdata); end
      cyc();
    end
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    cmp_cnt++; if (b_ifu_req_ready !== 1'b1) begin err_cnt++; $display("FAIL rstw_next_ready got %b exp 1", b_ifu_req_ready); end
    cyc(); ifu_req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) cyc();
      @(negedge clk);
      cmp_cnt++; if (b_ifu_resp_valid !== (c == 6)) begin err_cnt++; $display("FAIL rstw_next_resp_c%0d got %b exp %b", c, b_ifu_resp_valid, (c == 6)); end
    end
    cmp_cnt++; if (b_ifu_rdata !== 32'h0000_0077) begin err_cnt++; $display("FAIL rstw_next_rdata got %h exp 00000077", b_ifu_rdata); end
    idle(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ifu_fetch();
    test_store();
    test_conflict();
    test_lat4_load();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
